// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction prefetch buffer
// Purpose: default reset PC, the queued entry layout and the in-flight request limit.
// Ports: none (package).
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int MAX_OUTSTANDING = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - DEPTH-entry queue of {pc, instr} for the prefetch buffer
// Purpose: in-order storage with push/pop/flush; push and pop together keep occupancy.
// Ports: clk, rst (async active-low), push/pushData, pop, flush,
//        headData (oldest entry), full, empty, count (occupancy 0..DEPTH).
module prefetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             pushData,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             headData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   store [DEPTH];
  logic [AW-1:0]  rdPtr;
  logic [AW-1:0]  wrPtr;
  logic           doPush;
  logic           doPop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign headData = store[rdPtr];

  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign doPush = push && !flush && (!full || pop);
  assign doPop  = pop && !flush && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (!doPush && doPop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) store[wrPtr] <= pushData;
  end

  overflowCheck: assert property (@(posedge clk) disable iff (!rst)
                                  !(push && full && !pop && !flush))
    else $error("prefetch_fifo push into full queue");

endmodule

// File: rtl/instr_prefetch_buffer.sv
// rtl/instr_prefetch_buffer.sv - instruction prefetch buffer between imem and IF/ID
// Purpose: issues sequential word fetches under a credit limit, queues returning
//          words with their PC, and squashes in-flight fetches on a redirect.
//          Optional macro FETCH_BYPASS_EN: a response arriving at an empty queue
//          is presented combinationally in the same cycle.
// Ports: clk, rst (async active-low), redirect_valid/redirect_pc (branch target),
//        mem_req/mem_addr/mem_gnt/mem_rvalid/mem_rdata (imem port),
//        instr_valid/instr/instr_pc/instr_ready (to IF/ID, ready = ~stallD).
module instr_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]  fetchPc;
  logic [31:0]  respPc;
  logic [1:0]   outstanding;
  logic [1:0]   dropCnt;
  logic [1:0]   outNext;
  logic [1:0]   dropNext;
  logic [AW:0]  fifoCount;
  logic         fifoFull;
  logic         fifoEmpty;
  fetch_entry_t headData;
  fetch_entry_t pushData;
  logic         creditOk;
  logic         fire;
  logic         dropping;
  logic         accept;
  logic         headShown;
  logic         bypassHit;
  logic         fifoPush;
  logic         fifoPop;

  // Queue slots already filled plus words still in flight must fit the queue.
  assign creditOk = (32'(fifoCount) + 32'(outstanding)) < 32'(DEPTH);
  assign mem_req  = rst && creditOk && (outstanding < 2'(MAX_OUTSTANDING)) && !redirect_valid;
  assign mem_addr = fetchPc;
  assign fire     = mem_req && mem_gnt;

  // A word returning alongside a redirect is stale and is neither queued nor counted.
  assign dropping = mem_rvalid && (dropCnt != 2'd0);
  assign accept   = mem_rvalid && !dropping && !redirect_valid;
  assign pushData = '{pc: respPc, instr: mem_rdata};

  assign headShown = !fifoEmpty && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign bypassHit   = rst && accept && fifoEmpty;
  assign instr_valid = headShown || bypassHit;
  assign instr       = headShown ? headData.instr : (bypassHit ? mem_rdata : 32'h0);
  assign instr_pc    = headShown ? headData.pc    : (bypassHit ? respPc    : 32'h0);
`else
  assign bypassHit   = 1'b0;
  assign instr_valid = headShown;
  assign instr       = headShown ? headData.instr : 32'h0;
  assign instr_pc    = headShown ? headData.pc    : 32'h0;
`endif

  // A bypassed word consumed in its arrival cycle never enters the queue.
  assign fifoPush = accept && !(bypassHit && instr_ready);
  assign fifoPop  = headShown && instr_ready;

  always_comb begin
    outNext = outstanding;
    if (fire) outNext = outNext + 2'd1;
    if (mem_rvalid && (outNext != 2'd0)) outNext = outNext - 2'd1;
    dropNext = dropCnt;
    if (dropping) dropNext = dropNext - 2'd1;
    // Everything still in flight after this cycle belongs to the old stream;
    // outstanding never exceeds two, so accumulated drops cannot either.
    if (redirect_valid) dropNext = outNext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= 2'd0;
      dropCnt     <= 2'd0;
    end else begin
      outstanding <= outNext;
      dropCnt     <= dropNext;
      if (redirect_valid) begin
        fetchPc <= redirect_pc;
        respPc  <= redirect_pc;
      end else begin
        if (fire)   fetchPc <= fetchPc + 32'd4;
        if (accept) respPc  <= respPc + 32'd4;
      end
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifoPush),
    .pushData (pushData),
    .pop      (fifoPop),
    .flush    (redirect_valid),
    .headData (headData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  creditCheck: assert property (@(posedge clk) disable iff (!rst)
                                !(fifoFull && fifoPush && !fifoPop))
    else $error("instr_prefetch_buffer credit violated");

endmodule

// File: doc/instr_prefetch_buffer.md
INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port redirect_valid, input, 1 bit: the execute stage takes a branch or jump.
REQ-006 The block SHALL have port redirect_pc, input, 32 bits: the redirect target (PCTargetE or ALUResultE).
REQ-007 The block SHALL have port mem_req, output, 1 bit: instruction-memory read request.
REQ-008 The block SHALL have port mem_addr, output, 32 bits: the request address, word aligned.
REQ-009 The block SHALL have port mem_gnt, input, 1 bit: the request is accepted this cycle.
REQ-010 The block SHALL have port mem_rvalid, input, 1 bit: read data returns, in request order, at least 1 cycle after the grant.
REQ-011 The block SHALL have port mem_rdata, input, 32 bits: the returned instruction word.
REQ-012 The block SHALL have port instr_valid, output, 1 bit: the head entry is presented to IF/ID.
REQ-013 The block SHALL have port instr, output, 32 bits: the instruction presented (instrF).
REQ-014 The block SHALL have port instr_pc, output, 32 bits: the PC of instr (PCF); PC+4 is computed downstream.
REQ-015 The block SHALL have port instr_ready, input, 1 bit: IF/ID accepts the entry, driven as ~stallD.

Function
REQ-016 The block SHALL keep fetch_pc (next request address), resp_pc (PC of the next in-order response), an outstanding count (0..2), a drop count (0..2) and a DEPTH-entry FIFO of {pc, instr}.
REQ-017 The block SHALL assert mem_req when all of the following hold: occupancy + outstanding < DEPTH; outstanding < 2; no redirect this cycle. The block SHALL drive mem_addr = fetch_pc.
REQ-018 On mem_req & mem_gnt, the block SHALL increment fetch_pc by 4 (mod 2^32 wrap) and increment outstanding.
REQ-019 On mem_rvalid, the block SHALL decrement outstanding. If drop count > 0, the block SHALL discard the data and decrement drop count. Otherwise the block SHALL push {resp_pc, mem_rdata} and set resp_pc += 4.
REQ-020 The block SHALL pop the head on instr_valid & instr_ready. Push and pop in the same cycle SHALL leave occupancy unchanged, including when the FIFO is full. The credit rule SHALL make overflow impossible, and a push into a full FIFO is a design error (assertion).
REQ-021 Without a redirect, the block SHALL present a pushed entry on instr_valid the cycle after mem_rvalid (1-cycle latency). instr and instr_pc SHALL hold stable while instr_valid & !instr_ready.
REQ-022 On redirect_valid, the block SHALL do all of the following: empty the FIFO; force instr_valid low that cycle; set fetch_pc = resp_pc = redirect_pc; set drop count = outstanding after this cycle's grant/rvalid updates; issue no request that cycle. The new target SHALL be requested from the next cycle on.
REQ-023 When redirect_valid coincides with mem_rvalid, the block SHALL drop the returning word and exclude it from the new drop count.
REQ-024 The block SHALL accept back-to-back redirects. The last one wins, and drop counts SHALL accumulate without exceeding 2.
REQ-025 The block SHALL pass redirect_pc[1:0] unchanged; alignment is the producer's responsibility.

Reset
REQ-026 While rst is low, the block SHALL hold fetch_pc = resp_pc = RESET_PC, outstanding = drop = 0, FIFO empty, mem_req = 0, instr_valid = 0, instr = 0 and instr_pc = 0.
REQ-027 Reset asserted mid-transaction SHALL discard everything. After deassertion, the block SHALL ignore any stale mem_rvalid only if the memory was also reset. The memory SHALL share this reset.
REQ-028 The first mem_req SHALL occur in the first clock edge cycle after rst rises.

Configuration
REQ-029 With FETCH_BYPASS_EN defined, a non-dropped response arriving while the FIFO is empty SHALL appear combinationally on instr/instr_pc/instr_valid in the same cycle, and SHALL not be pushed if instr_ready is high that cycle (0-cycle latency).
REQ-030 Without FETCH_BYPASS_EN, the block SHALL have no combinational path from mem_rvalid/mem_rdata to outputs, and latency SHALL be exactly REQ-021.

Structure
REQ-031 Package fetch_pkg SHALL hold RESET_PC default, the fetch_entry_t typedef {pc[31:0], instr[31:0]} and the MAX_OUTSTANDING=2 constant.
REQ-032 The FIFO SHALL be sub-module prefetch_fifo (push/pop/flush, full/empty/count). The credit and drop logic SHALL stay in the top.

Verification
REQ-033 Reset release, mem_gnt=1, 1-cycle rvalid, instr_ready=1 -> addresses 0,4,8… issued every cycle, instr_pc 0,4,8 in order, no gaps after fill.
REQ-034 instr_ready=0 for 10 cycles -> exactly DEPTH=4 entries held, mem_req low once occupancy+outstanding=4, no lost or duplicated word on release.
REQ-035 Redirect to 32'h100 with 2 outstanding -> both stale responses dropped, first delivered instr_pc=32'h100.
REQ-036 Redirect in the same cycle as rvalid, then redirect again next cycle to 32'h200 -> only 32'h200 stream appears, drop count never >2.
REQ-037 fetch_pc=32'hFFFF_FFFC -> next request 32'h0000_0000.
REQ-038 FETCH_BYPASS_EN on, empty FIFO, rvalid with instr_ready=1 -> instr_valid same cycle, occupancy stays 0; off -> valid one cycle later.
